ex_operand_stage: RTL

- Holds the ID/EX and EX/MEM pipeline registers of the 5-stage RISC-V core. Consumes stall and forwarding flags from the hazard detector.
- Inserts a bubble on a load-use stall or a branch flush.
- Selects each ALU operand from the register file, the EX/MEM result, or the MEM/WB writeback value. Drives the ALU and the MEM stage.

---
 rtl/core_pkg.sv | 29 ++
 rtl/fwd_mux.sv | 26 ++
 rtl/ex_operand_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants for the 5-stage RISC-V core: datapath width, bubble word,
// opcodes and control-bit positions used across pipeline stages.
package core_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD  = 7'b000_0011;
  localparam logic [6:0] OP_RTYPE = 7'b011_0011;
  localparam logic [6:0] OP_ITYPE = 7'b001_0011;
  localparam logic [6:0] OP_JAL   = 7'b110_1111;
  localparam logic [6:0] OP_JALR  = 7'b110_0111;
  localparam logic [6:0] OP_LUI   = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC = 7'b001_0111;
  localparam logic [6:0] OP_ECALL = 7'b111_0011;

  // Bit positions inside the 5-bit ID/EX control word
  localparam int CTRL_REG_WRITE   = 4;
  localparam int CTRL_MEM_READ    = 3;
  localparam int CTRL_MEM_WRITE   = 2;
  localparam int CTRL_ALU_SRC_IMM = 1;
  localparam int CTRL_PC_SRC_A    = 0;

  // Bit positions inside the 3-bit EX/MEM control word
  localparam int MCTRL_REG_WRITE = 2;
  localparam int MCTRL_MEM_READ  = 1;
  localparam int MCTRL_MEM_WRITE = 0;

endpackage

// File: rtl/fwd_mux.sv
// Three-input priority operand mux: the EX/MEM result beats the MEM/WB value,
// which beats the register-file read.
module fwd_mux #(
  parameter int W = 32
) (
  input  logic         sel_ex_i,
  input  logic         sel_mem_i,
  input  logic [W-1:0] ex_val_i,
  input  logic [W-1:0] mem_val_i,
  input  logic [W-1:0] reg_val_i,
  output logic [W-1:0] fwd_o
);

  // Newest producer wins when both forwarding flags are set
  always_comb begin
    fwd_o = reg_val_i;
    if (sel_ex_i) begin
      fwd_o = ex_val_i;
    end else if (sel_mem_i) begin
      fwd_o = mem_val_i;
    end else begin
      fwd_o = reg_val_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX and EX/MEM pipeline registers with bubble insertion, operand forwarding
// and ALU operand selection.
module ex_operand_stage #(
  parameter int          XLEN     = core_pkg::XLEN,
  parameter logic [31:0] NOP_INST = core_pkg::NOP_INST,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             forwarding_EX_EX1,
  input  logic             forwarding_EX_EX2,
  input  logic             forwarding_MEM_EX1,
  input  logic             forwarding_MEM_EX2,
  input  logic [31:0]      id_inst,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_wb_data,
  output logic [31:0]      ex_inst,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op_a,
  output logic [XLEN-1:0]  ex_op_b,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [4:0]       ex_ctrl,
  output logic [XLEN-1:0]  exmem_result,
  output logic [4:0]       exmem_rd,
  output logic [2:0]       exmem_ctrl,
  output logic [XLEN-1:0]  exmem_store_data,
  output logic [CNT_W-1:0] bubble_count
);

  import core_pkg::*;

  logic [31:0]      ex_inst_q, ex_inst_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]  ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0]  ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [4:0]       ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic [XLEN-1:0]  exmem_result_q, exmem_result_d;
  logic [4:0]       exmem_rd_q, exmem_rd_d;
  logic [2:0]       exmem_ctrl_q, exmem_ctrl_d;
  logic [XLEN-1:0]  exmem_store_q, exmem_store_d;
  logic             bubble_s;
  logic [XLEN-1:0]  rs1_fwd_s, rs2_fwd_s;

  assign bubble_s = flush | stall;

  fwd_mux #(.W(XLEN)) u_fwd_rs1 (
    .sel_ex_i  (forwarding_EX_EX1),
    .sel_mem_i (forwarding_MEM_EX1),
    .ex_val_i  (exmem_result_q),
    .mem_val_i (mem_wb_data),
    .reg_val_i (ex_rs1_q),
    .fwd_o     (rs1_fwd_s)
  );

  fwd_mux #(.W(XLEN)) u_fwd_rs2 (
    .sel_ex_i  (forwarding_EX_EX2),
    .sel_mem_i (forwarding_MEM_EX2),
    .ex_val_i  (exmem_result_q),
    .mem_val_i (mem_wb_data),
    .reg_val_i (ex_rs2_q),
    .fwd_o     (rs2_fwd_s)
  );

  // ID/EX next state: a flush and a stall together still cost a single bubble
  always_comb begin
    ex_inst_d      = id_inst;
    ex_pc_d        = id_pc;
    ex_rs1_d       = id_rs1_data;
    ex_rs2_d       = id_rs2_data;
    ex_imm_d       = id_imm;
    ex_ctrl_d      = id_ctrl;
    bubble_count_d = bubble_count_q;
    if (bubble_s) begin
      ex_inst_d      = NOP_INST;
      ex_pc_d        = {XLEN{1'b0}};
      ex_rs1_d       = {XLEN{1'b0}};
      ex_rs2_d       = {XLEN{1'b0}};
      ex_imm_d       = {XLEN{1'b0}};
      ex_ctrl_d      = 5'd0;
      bubble_count_d = bubble_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_count_d = bubble_count_q;
    end
  end

  // EX/MEM next state: never stalls
  always_comb begin
    exmem_result_d = alu_result;
    exmem_rd_d     = ex_inst_q[11:7];
    exmem_ctrl_d   = {ex_ctrl_q[CTRL_REG_WRITE], ex_ctrl_q[CTRL_MEM_READ],
                      ex_ctrl_q[CTRL_MEM_WRITE]};
    exmem_store_d  = rs2_fwd_s;
  end

  // Pipeline register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_inst_q      <= NOP_INST;
      ex_pc_q        <= {XLEN{1'b0}};
      ex_rs1_q       <= {XLEN{1'b0}};
      ex_rs2_q       <= {XLEN{1'b0}};
      ex_imm_q       <= {XLEN{1'b0}};
      ex_ctrl_q      <= 5'd0;
      bubble_count_q <= {CNT_W{1'b0}};
      exmem_result_q <= {XLEN{1'b0}};
      exmem_rd_q     <= 5'd0;
      exmem_ctrl_q   <= 3'd0;
      exmem_store_q  <= {XLEN{1'b0}};
    end else begin
      ex_inst_q      <= ex_inst_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_imm_q       <= ex_imm_d;
      ex_ctrl_q      <= ex_ctrl_d;
      bubble_count_q <= bubble_count_d;
      exmem_result_q <= exmem_result_d;
      exmem_rd_q     <= exmem_rd_d;
      exmem_ctrl_q   <= exmem_ctrl_d;
      exmem_store_q  <= exmem_store_d;
    end
  end

  assign ex_inst          = ex_inst_q;
  assign ex_pc            = ex_pc_q;
  assign ex_ctrl          = ex_ctrl_q;
  assign ex_op_a          = ex_ctrl_q[CTRL_PC_SRC_A]    ? ex_pc_q  : rs1_fwd_s;
  assign ex_op_b          = ex_ctrl_q[CTRL_ALU_SRC_IMM] ? ex_imm_q : rs2_fwd_s;
  assign ex_store_data    = rs2_fwd_s;
  assign exmem_result     = exmem_result_q;
  assign exmem_rd         = exmem_rd_q;
  assign exmem_ctrl       = exmem_ctrl_q;
  assign exmem_store_data = exmem_store_q;
  assign bubble_count     = bubble_count_q;

endmodule
